// File: rtl/msb_pkg.sv
// Shared types and constants for the streaming set-bit enumerator.
`default_nettype none

package msb_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_e;

   localparam int unsigned EMPTY_POS = 0;

   // Width needed to hold a 1-based position 1..n, plus the 0 "no bit" code.
   function automatic int pos_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/msb_scanner_if.sv
// Word-in / position-out handshake bundle for msb_scanner.
`default_nettype none

interface msb_scanner_if
   import msb_pkg::*;
#(
   parameter int N = 32
);
   localparam int PW = pos_width(N);

   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  in_data;
   logic          in_lsb_first;
   logic          out_valid;
   logic          out_ready;
   logic [PW-1:0] out_pos;
   logic [PW-1:0] out_idx;
   logic          out_last;
   logic          out_empty;
   logic          busy;

   modport slave (
      input  in_valid, in_data, in_lsb_first, out_ready,
      output in_ready, out_valid, out_pos, out_idx, out_last, out_empty, busy
   );

   modport master (
      output in_valid, in_data, in_lsb_first, out_ready,
      input  in_ready, out_valid, out_pos, out_idx, out_last, out_empty, busy
   );

endinterface

`default_nettype wire

// File: rtl/seg_msb_find.sv
// Combinational finder: 1-based position of the highest or lowest set bit in one segment.
`default_nettype none

module seg_msb_find
   import msb_pkg::*;
#(
   parameter int SEG = 8,
   localparam int SPW = pos_width(SEG)
) (
   input  logic [SEG-1:0] seg_i,
   input  logic           lsb_first_i,
   output logic [SPW-1:0] pos_o,
   output logic           hit_o
);

   // Last match in loop order wins, so the scan direction picks the priority.
   always_comb begin : p_find
      pos_o = SPW'(EMPTY_POS);
      hit_o = |seg_i;
      if (lsb_first_i) begin
         for (int i = SEG - 1; i >= 0; i--) begin
            if (seg_i[i]) pos_o = SPW'(i + 1);
         end
      end else begin
         for (int i = 0; i < SEG; i++) begin
            if (seg_i[i]) pos_o = SPW'(i + 1);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/msb_scanner.sv
// Streaming set-bit enumerator: accepts one word, then emits every set-bit position, one per beat.
`default_nettype none

module msb_scanner
   import msb_pkg::*;
#(
   parameter int N   = 32,
   parameter int SEG = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   msb_scanner_if.slave  bus
);

   localparam int PW   = pos_width(N);
   localparam int SPW  = pos_width(SEG);
   localparam int NSEG = N / SEG;

   state_e        state_q, state_d;
   logic [N-1:0]  rem_q, rem_d;
   logic          mode_q, mode_d;
   logic [PW-1:0] idx_q, idx_d;
   logic          empty_q, empty_d;

   logic [SPW-1:0] seg_pos [NSEG];
   logic [NSEG-1:0] seg_hit;
   logic [PW-1:0]  pos;
   logic           last;
   logic [N-1:0]   clr_mask;

   generate
      for (genvar g = 0; g < NSEG; g++) begin : g_seg
         seg_msb_find #(.SEG(SEG)) u_find (
            .seg_i       (rem_q[g*SEG +: SEG]),
            .lsb_first_i (mode_q),
            .pos_o       (seg_pos[g]),
            .hit_o       (seg_hit[g])
         );
      end
   endgenerate

   // Pick the winning segment in scan order and add its base offset.
   always_comb begin : p_select
      pos = PW'(EMPTY_POS);
      if (mode_q) begin
         for (int s = NSEG - 1; s >= 0; s--) begin
            if (seg_hit[s]) pos = PW'(s * SEG) + PW'(seg_pos[s]);
         end
      end else begin
         for (int s = 0; s < NSEG; s++) begin
            if (seg_hit[s]) pos = PW'(s * SEG) + PW'(seg_pos[s]);
         end
      end
   end

   assign last     = ((rem_q & (rem_q - N'(1))) == '0);
   assign clr_mask = (pos == '0) ? '0 : (N'(1) << (pos - PW'(1)));

   assign bus.out_pos = pos;
   assign bus.out_idx = idx_q;

   always_comb begin : p_fsm
      state_d       = state_q;
      rem_d         = rem_q;
      mode_d        = mode_q;
      idx_d         = idx_q;
      empty_d       = empty_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_last  = 1'b0;
      bus.out_empty = 1'b0;
      bus.busy      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               rem_d   = bus.in_data;
               mode_d  = bus.in_lsb_first;
               idx_d   = '0;
               empty_d = (bus.in_data == '0);
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            bus.out_valid = 1'b1;
            bus.busy      = 1'b1;
            bus.out_last  = last;
            bus.out_empty = empty_q;
            if (bus.out_ready) begin
               if (last) begin
                  state_d = ST_IDLE;
                  rem_d   = '0;
                  idx_d   = '0;
               end else begin
                  rem_d = rem_q & ~clr_mask;
                  idx_d = idx_q + PW'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin : p_regs
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         mode_q  <= 1'b0;
         idx_q   <= '0;
         empty_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         mode_q  <= mode_d;
         idx_q   <= idx_d;
         empty_q <= empty_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_msb_scanner.sv
// Self-checking bench for msb_scanner: table of words plus backpressure, wide-word and reset sequences.
`default_nettype none

module tb_msb_scanner;

   typedef struct {
      int pos;
      int idx;
      bit last;
      bit empty;
   } beat_t;

   typedef struct {
      logic [31:0] data;
      bit          lsb;
      int          beats;
      int          first;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   msb_scanner_if #(.N(32)) a ();
   msb_scanner_if #(.N(64)) b ();

   msb_scanner #(.N(32), .SEG(8)) u_dut32 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (a)
   );

   msb_scanner #(.N(64), .SEG(16)) u_dut64 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b)
   );

   beat_t q32[$];
   beat_t q64[$];
   int    n_vec  = 0;
   int    n_miss = 0;
   int    beats32 = 0;
   int    beats64 = 0;
   int    first32 = -1;
   vec_t  vt[9];

   task automatic check(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference: walk bits in the requested order and queue one beat per set bit.
   function automatic void push32(input logic [31:0] d, input bit lsb);
      int cnt, k, bi;
      cnt = $countones(d);
      k   = 0;
      if (d == '0) q32.push_back('{0, 0, 1'b1, 1'b1});
      for (int j = 0; j < 32; j++) begin
         bi = lsb ? j : 31 - j;
         if (d[bi]) begin
            q32.push_back('{bi + 1, k, (k == cnt - 1), 1'b0});
            k++;
         end
      end
   endfunction

   // One cycle: score any handshaking beat at the falling edge, then step past the rising edge.
   task automatic tick();
      beat_t e;
      @(negedge clk);
      if (a.out_valid && a.out_ready) begin
         beats32++;
         if (a.out_idx == 0) first32 = int'(a.out_pos);
         if (q32.size() == 0) check("sb32_extra_beat", 1, 0);
         else begin
            e = q32.pop_front();
            check("pos32", int'(a.out_pos), e.pos);
            check("idx32", int'(a.out_idx), e.idx);
            check("last32", int'(a.out_last), int'(e.last));
            check("empty32", int'(a.out_empty), int'(e.empty));
         end
      end
      if (b.out_valid && b.out_ready) begin
         beats64++;
         if (q64.size() == 0) check("sb64_extra_beat", 1, 0);
         else begin
            e = q64.pop_front();
            check("pos64", int'(b.out_pos), e.pos);
            check("idx64", int'(b.out_idx), e.idx);
            check("last64", int'(b.out_last), int'(e.last));
            check("empty64", int'(b.out_empty), int'(e.empty));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send32(input logic [31:0] d, input bit lsb);
      int t;
      t = 0;
      while (!a.in_ready && t < 100) begin
         tick();
         t++;
      end
      check("send_ready", int'(a.in_ready), 1);
      push32(d, lsb);
      a.in_valid     = 1'b1;
      a.in_data      = d;
      a.in_lsb_first = lsb;
      tick();
      a.in_valid     = 1'b0;
   endtask

   task automatic drain32(input string nm, input int exp_beats, input int exp_first,
                          output int cyc);
      int b0;
      b0  = beats32;
      cyc = 0;
      while (a.busy && cyc < 300) begin
         tick();
         cyc++;
      end
      check({nm, "_done"}, int'(a.busy), 0);
      check({nm, "_beats"}, beats32 - b0, exp_beats);
      check({nm, "_first"}, first32, exp_first);
      check({nm, "_sb"}, q32.size(), 0);
      check({nm, "_rdy"}, int'(a.in_ready), 1);
   endtask

   initial begin
      int cyc, b0;

      vt[0] = '{32'h8000_0001, 1'b0,  2, 32};
      vt[1] = '{32'h0000_0000, 1'b0,  1,  0};
      vt[2] = '{32'h0000_0104, 1'b1,  2,  3};
      vt[3] = '{32'hFFFF_FFFF, 1'b1, 32,  1};
      vt[4] = '{32'h0000_0100, 1'b0,  1,  9};
      vt[5] = '{32'h8000_0000, 1'b1,  1, 32};
      vt[6] = '{32'h1234_5678, 1'b0, 13, 29};
      vt[7] = '{32'h1234_5678, 1'b1, 13,  4};
      vt[8] = '{32'h0001_8000, 1'b0,  2, 17};

      rst_n          = 1'b0;
      a.in_valid     = 1'b0;
      a.in_data      = '0;
      a.in_lsb_first = 1'b0;
      a.out_ready    = 1'b1;
      b.in_valid     = 1'b0;
      b.in_data      = '0;
      b.in_lsb_first = 1'b0;
      b.out_ready    = 1'b1;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", int'(a.in_ready), 1);
      check("rst_out_valid", int'(a.out_valid), 0);
      check("rst_out_pos", int'(a.out_pos), 0);
      check("rst_out_idx", int'(a.out_idx), 0);
      check("rst_out_last", int'(a.out_last), 0);
      check("rst_out_empty", int'(a.out_empty), 0);
      check("rst_busy", int'(a.busy), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      foreach (vt[i]) begin
         send32(vt[i].data, vt[i].lsb);
         drain32($sformatf("vec%0d", i), vt[i].beats, vt[i].first, cyc);
         check($sformatf("vec%0d_cycles", i), cyc, vt[i].beats);
      end

      // Backpressure with a competing word offered mid-scan.
      a.out_ready = 1'b0;
      send32(32'hF000_0000, 1'b0);
      a.in_valid     = 1'b1;
      a.in_data      = 32'h0000_FFFF;
      a.in_lsb_first = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_valid", int'(a.out_valid), 1);
         check("bp_pos", int'(a.out_pos), 32);
         check("bp_idx", int'(a.out_idx), 0);
         check("bp_last", int'(a.out_last), 0);
         check("bp_in_ready", int'(a.in_ready), 0);
      end
      a.in_valid  = 1'b0;
      a.out_ready = 1'b1;
      drain32("bp", 4, 32, cyc);
      check("bp_cycles", cyc, 4);

      // 64-bit all-ones word on the wide instance.
      for (int i = 0; i < 64; i++) q64.push_back('{64 - i, i, (i == 63), 1'b0});
      b.in_valid     = 1'b1;
      b.in_data      = '1;
      b.in_lsb_first = 1'b0;
      tick();
      b.in_valid = 1'b0;
      b0  = beats64;
      cyc = 0;
      while (b.busy && cyc < 300) begin
         tick();
         cyc++;
      end
      check("w64_done", int'(b.busy), 0);
      check("w64_beats", beats64 - b0, 64);
      check("w64_cycles", cyc, 64);
      check("w64_sb", q64.size(), 0);

      // Reset in the middle of a scan.
      send32(32'hFFFF_FFFF, 1'b0);
      repeat (5) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("mrst_out_valid", int'(a.out_valid), 0);
      check("mrst_busy", int'(a.busy), 0);
      check("mrst_out_pos", int'(a.out_pos), 0);
      check("mrst_out_idx", int'(a.out_idx), 0);
      check("mrst_out_last", int'(a.out_last), 0);
      q32.delete();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("mrst_in_ready", int'(a.in_ready), 1);
      send32(32'h0000_0010, 1'b0);
      drain32("post_rst", 1, 5, cyc);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

`default_nettype wire
